// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns EX/MEM load/store requests into a held,
// big-endian data-memory request, stalls until completion and latches the read word.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic [31:0] ALUOut,
    input  logic [31:0] StoreData,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemWE,
    output logic [31:0] MemWData,
    input  logic        MemReady,
    input  logic [31:0] MemRData,
    output logic [31:0] MemOut,
    output logic        Stall,
    output logic        AccessExc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BAD  = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // Big-endian lane select: byte offset 0 drives bits 31:24 (enable bit 3).
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: begin
                case (lo)
                    2'b00:   be = 4'b1000;
                    2'b01:   be = 4'b0100;
                    2'b10:   be = 4'b0010;
                    2'b11:   be = 4'b0001;
                    default: be = 4'b0000;
                endcase
            end
            SZ_HALF: be = lo[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wd;
        wd = 32'h0000_0000;
        case (size)
            SZ_BYTE: wd = {4{data[7:0]}};
            SZ_HALF: wd = {2{data[15:0]}};
            SZ_WORD: wd = data;
            default: wd = 32'h0000_0000;
        endcase
        return wd;
    endfunction

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_we_q, mem_we_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] mem_out_q, mem_out_d;
    logic        is_load_q, is_load_d;

    logic        any_op_s;
    logic        req_s;
    logic        illegal_s;
    logic        stall_s;
    logic        exc_s;

    assign any_op_s  = MemRead | MemWrite;
    assign req_s     = MemRead ^ MemWrite;
    assign illegal_s = (MemRead & MemWrite)
                     | (any_op_s & (MemSize == SZ_BAD))
                     | (any_op_s & (MemSize == SZ_HALF) & ALUOut[0])
                     | (any_op_s & (MemSize == SZ_WORD) & (ALUOut[1:0] != 2'b00));

    // Next-state, request capture and stall/exception decode.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        mem_out_d   = mem_out_q;
        is_load_d   = is_load_q;
        stall_s     = 1'b0;
        exc_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (illegal_s) begin
                    exc_s = 1'b1;
                end else if (req_s) begin
                    mem_addr_d  = {ALUOut[31:2], 2'b00};
                    mem_we_d    = MemWrite ? byte_en(MemSize, ALUOut[1:0]) : 4'b0000;
                    mem_wdata_d = store_rep(MemSize, StoreData);
                    is_load_d   = MemRead;
                    mem_req_d   = 1'b1;
                    stall_s     = 1'b1;
                    state_d     = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_s = 1'b1;
                if (MemReady) begin
                    if (is_load_q) begin
                        mem_out_d = MemRData;
                    end else begin
                        mem_out_d = mem_out_q;
                    end
                    mem_req_d = 1'b0;
                    mem_we_d  = 4'b0000;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            // The pipeline advances at the end of DONE, so inputs here still show the old instruction.
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 4'b0000;
            end
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_we_q    <= 4'b0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_out_q   <= 32'h0000_0000;
            is_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            mem_out_q   <= mem_out_d;
            is_load_q   <= is_load_d;
        end
    end

    assign MemReq    = mem_req_q;
    assign MemAddr   = mem_addr_q;
    assign MemWE     = mem_we_q;
    assign MemWData  = mem_wdata_q;
    assign MemOut    = mem_out_q;
    assign Stall     = stall_s & ~rst;
    assign AccessExc = exc_s & ~rst;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected transactions,
// a negedge monitor pops and checks them when the DUT raises a request or an exception.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [1:0]  MemSize;
    logic [31:0] ALUOut, StoreData;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic [3:0]  MemWE;
    logic [31:0] MemWData;
    logic        MemReady;
    logic [31:0] MemRData;
    logic [31:0] MemOut;
    logic        Stall, AccessExc;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
        .ALUOut(ALUOut), .StoreData(StoreData),
        .MemReq(MemReq), .MemAddr(MemAddr), .MemWE(MemWE), .MemWData(MemWData),
        .MemReady(MemReady), .MemRData(MemRData), .MemOut(MemOut),
        .Stall(Stall), .AccessExc(AccessExc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          exc;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] out;
        logic [31:0] pre_out;
        int          req_cycles;
        int          stall_cycles;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_out = 32'h0000_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: tracks request lifetime and stall length, compares against the queue.
    exp_t cur;
    bit   active = 1'b0;
    bit   prev_req = 1'b0;
    int   req_cnt = 0;
    int   stall_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0; prev_req = 1'b0; req_cnt = 0; stall_cnt = 0;
            end else begin
                if (AccessExc) begin
                    if (q.size() == 0) begin
                        chk("unexpected_exc", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("exc_expected", {31'd0, e.exc}, 32'd1);
                        chk("exc_stall", {31'd0, Stall}, 32'd0);
                        chk("exc_memreq", {31'd0, MemReq}, 32'd0);
                    end
                end
                if (Stall) stall_cnt++;
                if (MemReq && !active) begin
                    if (q.size() == 0) begin
                        chk("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        cur = q.pop_front();
                        active = 1'b1;
                        req_cnt = 0;
                        chk("req_not_exc", {31'd0, cur.exc}, 32'd0);
                        chk("req_we", {28'd0, MemWE}, {28'd0, cur.we});
                        chk("req_wdata", MemWData, cur.wdata);
                    end
                end
                if (MemReq && active) begin
                    req_cnt++;
                    chk("busy_addr", MemAddr, cur.addr);
                    chk("busy_out_hold", MemOut, cur.pre_out);
                end
                if (!MemReq && prev_req && active) begin
                    chk("done_out", MemOut, cur.out);
                    chk("done_we", {28'd0, MemWE}, 32'd0);
                    chk("done_stall", {31'd0, Stall}, 32'd0);
                    chk("req_cycles", req_cnt, cur.req_cycles);
                    chk("stall_cycles", stall_cnt, cur.stall_cycles);
                    active = 1'b0;
                    stall_cnt = 0;
                end else if (!active && !Stall) begin
                    stall_cnt = 0;
                end
                prev_req = MemReq;
            end
        end
    end

    task automatic clear_inputs();
        MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b00;
        ALUOut = 32'h0; StoreData = 32'h0; MemReady = 1'b0; MemRData = 32'h0;
    endtask

    // Legal access: held for IDLE, d wait cycles, ready cycle, DONE.
    task automatic do_access(input bit rd, input bit wr, input logic [1:0] sz,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input int d, input logic [31:0] rdata, input bit ready_in_done,
                             input logic [3:0] exp_we, input logic [31:0] exp_wdata);
        exp_t e;
        e.exc = 1'b0;
        e.addr = {addr[31:2], 2'b00};
        e.we = exp_we;
        e.wdata = exp_wdata;
        e.pre_out = model_out;
        if (rd) model_out = rdata;
        e.out = model_out;
        e.req_cycles = d + 1;
        e.stall_cycles = d + 2;
        q.push_back(e);
        MemRead = rd; MemWrite = wr; MemSize = sz; ALUOut = addr; StoreData = sdata;
        @(posedge clk); #1;
        repeat (d) begin
            MemRData = 32'h5A5A_5A5A;
            @(posedge clk); #1;
        end
        MemReady = 1'b1; MemRData = rdata;
        @(posedge clk); #1;
        MemReady = ready_in_done; MemRData = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic do_illegal(input bit rd, input bit wr, input logic [1:0] sz, input logic [31:0] addr);
        exp_t e;
        e.exc = 1'b1; e.addr = 32'h0; e.we = 4'h0; e.wdata = 32'h0;
        e.out = model_out; e.pre_out = model_out; e.req_cycles = 0; e.stall_cycles = 0;
        q.push_back(e);
        MemRead = rd; MemWrite = wr; MemSize = sz; ALUOut = addr; StoreData = 32'hFFFF_FFFF;
        MemReady = 1'b1; MemRData = 32'hEEEE_EEEE;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        MemRead = 1'b1; MemSize = 2'b11; ALUOut = 32'h0000_0100;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_exc", {31'd0, AccessExc}, 32'd0);
        chk("rst_memreq", {31'd0, MemReq}, 32'd0);
        chk("rst_we", {28'd0, MemWE}, 32'd0);
        chk("rst_addr", MemAddr, 32'd0);
        chk("rst_wdata", MemWData, 32'd0);
        chk("rst_out", MemOut, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        @(posedge clk); #1;

        do_access(1'b1, 1'b0, 2'b11, 32'h0000_0100, 32'h0000_0000, 0, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0000_0000);
        do_access(1'b0, 1'b1, 2'b00, 32'h0000_0203, 32'h1234_5678, 0, 32'h0, 1'b0, 4'b0001, 32'h7878_7878);
        do_access(1'b0, 1'b1, 2'b01, 32'h0000_0302, 32'hAAAA_5555, 0, 32'h0, 1'b0, 4'b0011, 32'h5555_5555);
        do_access(1'b1, 1'b0, 2'b11, 32'h0000_0400, 32'h0000_0000, 4, 32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0000_0000);
        do_access(1'b1, 1'b0, 2'b01, 32'h0000_0102, 32'h0000_0000, 1, 32'h0BAD_F00D, 1'b1, 4'b0000, 32'h0000_0000);
        do_access(1'b0, 1'b1, 2'b00, 32'h0000_0001, 32'h0000_00AB, 0, 32'h0, 1'b0, 4'b0100, 32'hABAB_ABAB);
        do_access(1'b0, 1'b1, 2'b11, 32'h0000_0404, 32'h1122_3344, 2, 32'h0, 1'b0, 4'b1111, 32'h1122_3344);
        do_access(1'b1, 1'b0, 2'b00, 32'h0000_0003, 32'h0000_00C3, 0, 32'h0000_0077, 1'b0, 4'b0000, 32'hC3C3_C3C3);

        do_illegal(1'b1, 1'b0, 2'b11, 32'h0000_0102);
        do_illegal(1'b0, 1'b1, 2'b01, 32'h0000_0101);
        do_illegal(1'b1, 1'b0, 2'b10, 32'h0000_0000);
        do_illegal(1'b1, 1'b1, 2'b00, 32'h0000_0000);
        @(posedge clk); #1;

        begin
            exp_t e;
            e.exc = 1'b0; e.addr = 32'h0000_0500; e.we = 4'b0000; e.wdata = 32'h0;
            e.out = 32'h0; e.pre_out = model_out; e.req_cycles = 0; e.stall_cycles = 0;
            q.push_back(e);
            MemRead = 1'b1; MemSize = 2'b11; ALUOut = 32'h0000_0500;
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst = 1'b1;
            @(negedge clk);
            chk("midrst_stall", {31'd0, Stall}, 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            clear_inputs();
            model_out = 32'h0000_0000;
            @(negedge clk);
            chk("midrst_memreq", {31'd0, MemReq}, 32'd0);
            chk("midrst_out", MemOut, 32'd0);
            chk("midrst_stall_after", {31'd0, Stall}, 32'd0);
            @(posedge clk); #1;
        end

        do_access(1'b0, 1'b1, 2'b01, 32'h0000_0000, 32'h0000_BEEF, 0, 32'h0, 1'b0, 4'b1100, 32'hBEEF_BEEF);
        do_access(1'b1, 1'b0, 2'b11, 32'h0000_0600, 32'h0000_0000, 1, 32'h600D_CAFE, 1'b0, 4'b0000, 32'h0000_0000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        chk("no_open_request", {31'd0, active}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller between the EX/MEM pipeline register and the data-memory port. It turns load/store requests into a held memory request with big-endian byte enables and replicated store data. It stalls the pipeline until the memory handshakes, then latches the raw read word into `MemOut`, which feeds the load-extraction stage directly downstream. Illegal or misaligned accesses never reach memory; they raise a one-cycle exception.

## Interface

No parameters; all widths are fixed.

- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `MemRead` input 1: the instruction in MEM is a load.
- `MemWrite` input 1: the instruction in MEM is a store.
- `MemSize` input 2: access size, 00 = byte, 01 = half, 11 = word, 10 = illegal.
- `ALUOut` input 32: byte address of the access.
- `StoreData` input 32: rt value; the low byte or half is used for sub-word stores.
- `MemReq` output 1: request valid to memory, registered.
- `MemAddr` output 32: word-aligned address, `{ALUOut[31:2], 2'b00}`, registered.
- `MemWE` output 4: byte write enables, bit 3 = bits 31:24; all zero for loads.
- `MemWData` output 32: replicated store data, registered.
- `MemReady` input 1: memory completion; read data is valid in the same cycle.
- `MemRData` input 32: read word from memory.
- `MemOut` output 32: latched read word passed to the downstream extraction stage.
- `Stall` output 1: freeze the PC and all pipeline registers, combinational.
- `AccessExc` output 1: illegal or misaligned access, combinational, one cycle.

## Operation

- The FSM has three states: IDLE, BUSY, DONE.
- A request is `Req = MemRead ^ MemWrite`.
- An access is illegal when any of these hold:
  - `MemRead & MemWrite`;
  - `MemSize == 10` with `MemRead | MemWrite`;
  - half access with `ALUOut[0] = 1`;
  - word access with `ALUOut[1:0] != 00`.
- IDLE:
  - Illegal access: `AccessExc = 1`, no request, no stall, stay in IDLE.
  - Legal `Req`: capture `MemAddr`, `MemWE` and `MemWData`, set `MemReq = 1`, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Hold `MemReq` and all request outputs stable.
  - On `MemReady`: if the access is a load, load `MemRData` into `MemOut`; clear `MemReq` and `MemWE`; go to DONE.
  - Otherwise stay in BUSY.
- DONE: ignore all inputs for one cycle, then go to IDLE. The pipeline advances at the end of this cycle, so the same instruction is never reissued.
- Byte enables, big-endian:
  - Byte: `ALUOut[1:0]` = 00 → 1000, 01 → 0100, 10 → 0010, 11 → 0001.
  - Half: `ALUOut[1]` = 0 → 1100, 1 → 0011.
  - Word: 1111.
- Store data: byte → `{4{StoreData[7:0]}}`; half → `{2{StoreData[15:0]}}`; word → `StoreData`.
- `MemOut` is updated only by a completed load; stores leave it unchanged.
- Stall rule: `Stall = (IDLE & legal Req) | BUSY`. `Stall` is 0 in DONE and for illegal accesses.

## Timing

- Reset values: state IDLE; `MemReq`, `MemWE`, `MemAddr`, `MemWData` and `MemOut` all 0; `Stall` and `AccessExc` 0 while reset is asserted.
- Minimum latency, request presented in cycle N:
  - `MemReq` is high from cycle N+1.
  - If `MemReady` is also high in N+1, DONE is cycle N+2 and `MemOut` is valid in N+2.
  - `Stall` is high in N and N+1 only.
- Each wait cycle of memory adds one BUSY cycle and one stall cycle.
- Handshake: memory samples `MemAddr`, `MemWE` and `MemWData` only while `MemReq` is high. The block never drops `MemReq` before `MemReady`, and never asserts it in the cycle after `MemReady`.
- `MemReady` while not in BUSY is ignored.
- Back-to-back accesses: the second request is accepted in the IDLE cycle after DONE, so the throughput is one access per 3 cycles at zero wait states.
- Reset mid-operation: the next edge returns to IDLE with `MemReq` = 0. An abandoned request must be tolerated by memory, and `MemOut` is cleared.

## Test plan

- Word load at 0x100, `MemReady` in the first BUSY cycle, `MemRData` = 0xDEADBEEF:
  - `MemReq` high for 1 cycle, `MemWE` = 0000;
  - `Stall` high 2 cycles;
  - `MemOut` = 0xDEADBEEF in DONE.
- Byte store of 0x12345678 at 0x203: `MemAddr` = 0x200, `MemWE` = 0001, `MemWData` = 0x78787878, `MemOut` unchanged.
- Half store of 0xAAAA5555 at 0x0302: `MemWE` = 0011, `MemWData` = 0x55555555.
- Load with `MemReady` delayed 4 cycles: `MemReq` and `MemAddr` stable for 5 cycles, `Stall` high for 6 cycles, single capture of the read word.
- Illegal accesses: word load at 0x102, half store at 0x101, and `MemSize` = 10 each give `AccessExc` = 1 for one cycle, `Stall` = 0 and `MemReq` never asserted.
- `rst` asserted during a BUSY wait: next cycle state is IDLE, `MemReq` = 0 and `MemOut` = 0, and a later access completes normally.
